// File: rtl/ripple_count_monitor_if.sv
// Bundle between the ripple counter and its capture/monitor stage:
// the raw asynchronous count in, accepted count and status flags out.
interface ripple_count_monitor_if #(
  parameter int unsigned WRAP_W = 8
);
  logic [3:0]        q_async;
  logic [3:0]        count;
  logic              count_valid;
  logic              step;
  logic              wrap;
  logic              skip_err;
  logic [WRAP_W-1:0] wrap_count;
  logic              paused;
  logic [6:0]        seg;

  modport master (
    output q_async,
    input  count, count_valid, step, wrap, skip_err, wrap_count, paused, seg
  );

  modport slave (
    input  q_async,
    output count, count_valid, step, wrap, skip_err, wrap_count, paused, seg
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// Synchronizes and de-glitches a 4-bit ripple down-counter, tracks accepted
// values, flags step/wrap/skip/pause and drives an active-low hex digit.
module ripple_count_monitor #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned PAUSE_CYCLES  = 16,
  parameter int unsigned WRAP_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  ripple_count_monitor_if.slave   bus
);

  localparam logic [0:0]        ST_ACQUIRE = 1'b0;
  localparam logic [0:0]        ST_TRACK   = 1'b1;
  localparam logic [3:0]        STAB_LAST  = 4'(STABLE_CYCLES - 1);
  localparam logic [7:0]        PAUSE_MAX  = 8'(PAUSE_CYCLES);
  localparam logic [WRAP_W-1:0] WRAP_MAX   = '1;
  localparam logic [6:0]        SEG_BLANK  = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [3:0]        s1_q, s2_q;
  logic [1:0]        fill_q, fill_d;
  logic [3:0]        cand_q, cand_d;
  logic              cand_vld_q, cand_vld_d;
  logic [3:0]        stab_q, stab_d;
  logic              acc_done_q, acc_done_d;
  logic              accept_s;
  logic [0:0]        state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              count_valid_q, count_valid_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic              skip_q, skip_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic [7:0]        idle_q, idle_d;
  logic              paused_q, paused_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        prev_m1_s;

  // fill_q marks when s2 holds a real sample rather than its reset zero,
  // so a post-reset zero is never mistaken for a stable counter value.
  always_comb begin
    fill_d     = {fill_q[0], 1'b1};
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    stab_d     = stab_q;
    acc_done_d = acc_done_q;
    accept_s   = 1'b0;
    if (fill_q[1]) begin
      if ((s2_q != cand_q) || !cand_vld_q) begin
        cand_d     = s2_q;
        cand_vld_d = 1'b1;
        stab_d     = 4'd0;
        acc_done_d = 1'b0;
      end else if (!acc_done_q && (stab_q == STAB_LAST)) begin
        accept_s   = 1'b1;
        acc_done_d = 1'b1;
      end else if (!acc_done_q) begin
        stab_d = stab_q + 4'd1;
      end else begin
        stab_d = stab_q;
      end
    end else begin
      cand_d = cand_q;
    end
  end

  assign prev_m1_s = count_q - 4'd1;

  // Tracking FSM; pulses, pause and the digit are computed from next-state values.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    count_valid_d = count_valid_q;
    step_d        = 1'b0;
    wrap_d        = 1'b0;
    skip_d        = 1'b0;
    idle_d        = idle_q;
    case (state_q)
      ST_ACQUIRE: begin
        idle_d = 8'd0;
        if (accept_s) begin
          count_d       = cand_q;
          count_valid_d = 1'b1;
          state_d       = ST_TRACK;
        end else begin
          count_valid_d = 1'b0;
        end
      end
      ST_TRACK: begin
        if (accept_s && (cand_q != count_q)) begin
          count_d = cand_q;
          idle_d  = 8'd0;
          step_d  = (cand_q == prev_m1_s);
          wrap_d  = (count_q == 4'h0) && (cand_q == 4'hF);
          skip_d  = (cand_q != prev_m1_s);
        end else if (idle_q != PAUSE_MAX) begin
          idle_d = idle_q + 8'd1;
        end else begin
          idle_d = idle_q;
        end
      end
      default: begin
        state_d       = ST_ACQUIRE;
        count_valid_d = 1'b0;
        idle_d        = 8'd0;
      end
    endcase

    if (wrap_d && (wrap_count_q != WRAP_MAX)) begin
      wrap_count_d = wrap_count_q + WRAP_W'(1);
    end else begin
      wrap_count_d = wrap_count_q;
    end

    paused_d = (state_d == ST_TRACK) && (idle_d == PAUSE_MAX);
    if (state_d == ST_TRACK) begin
      seg_d = hex_to_seg(count_d);
    end else begin
      seg_d = SEG_BLANK;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q          <= 4'd0;
      s2_q          <= 4'd0;
      fill_q        <= 2'd0;
      cand_q        <= 4'd0;
      cand_vld_q    <= 1'b0;
      stab_q        <= 4'd0;
      acc_done_q    <= 1'b0;
      state_q       <= ST_ACQUIRE;
      count_q       <= 4'd0;
      count_valid_q <= 1'b0;
      step_q        <= 1'b0;
      wrap_q        <= 1'b0;
      skip_q        <= 1'b0;
      wrap_count_q  <= '0;
      idle_q        <= 8'd0;
      paused_q      <= 1'b0;
      seg_q         <= SEG_BLANK;
    end else begin
      s1_q          <= bus.q_async;
      s2_q          <= s1_q;
      fill_q        <= fill_d;
      cand_q        <= cand_d;
      cand_vld_q    <= cand_vld_d;
      stab_q        <= stab_d;
      acc_done_q    <= acc_done_d;
      state_q       <= state_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      step_q        <= step_d;
      wrap_q        <= wrap_d;
      skip_q        <= skip_d;
      wrap_count_q  <= wrap_count_d;
      idle_q        <= idle_d;
      paused_q      <= paused_d;
      seg_q         <= seg_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.step        = step_q;
  assign bus.wrap        = wrap_q;
  assign bus.skip_err    = skip_q;
  assign bus.wrap_count  = wrap_count_q;
  assign bus.paused      = paused_q;
  assign bus.seg         = seg_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: acquisition, down-count with wrap,
// glitch rejection, illegal jump, pause, wrap saturation and mid-run reset.
module tb_ripple_count_monitor;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n_step;
  int   n_wrap;
  int   n_skip;
  logic zero_seen;

  ripple_count_monitor_if #(.WRAP_W(2)) bus ();

  ripple_count_monitor #(
    .STABLE_CYCLES(2),
    .PAUSE_CYCLES (16),
    .WRAP_W       (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.step)     n_step++;
    if (bus.wrap)     n_wrap++;
    if (bus.skip_err) n_skip++;
    if (bus.count_valid && (bus.count == 4'h0)) zero_seen = 1'b1;
  endtask

  task automatic clr_tally();
    n_step    = 0;
    n_wrap    = 0;
    n_skip    = 0;
    zero_seen = 1'b0;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    bus.q_async = v;
    repeat (n) tick();
  endtask

  task automatic check_reset_vals(input string t);
    check_val({t, "_rst_count"},  32'(bus.count),       32'h0);
    check_val({t, "_rst_valid"},  32'(bus.count_valid), 32'h0);
    check_val({t, "_rst_step"},   32'(bus.step),        32'h0);
    check_val({t, "_rst_wrap"},   32'(bus.wrap),        32'h0);
    check_val({t, "_rst_skip"},   32'(bus.skip_err),    32'h0);
    check_val({t, "_rst_wcnt"},   32'(bus.wrap_count),  32'h0);
    check_val({t, "_rst_paused"}, 32'(bus.paused),      32'h0);
    check_val({t, "_rst_seg"},    32'(bus.seg),         32'h7F);
  endtask

  // Releases reset with A on the input; A must appear exactly at edge 4.
  task automatic acquire_check(input string t);
    reset       = 1'b0;
    bus.q_async = 4'hA;
    clr_tally();
    repeat (4) tick();
    check_val({t, "_e3_valid"}, 32'(bus.count_valid), 32'h0);
    check_val({t, "_e3_seg"},   32'(bus.seg),         32'h7F);
    tick();
    check_val({t, "_e4_count"}, 32'(bus.count),       32'hA);
    check_val({t, "_e4_valid"}, 32'(bus.count_valid), 32'h1);
    check_val({t, "_e4_seg"},   32'(bus.seg),         32'b0001000);
    check_val({t, "_e4_pulses"}, 32'(n_step + n_wrap + n_skip), 32'h0);
  endtask

  initial begin
    logic found;
    logic prev_paused;
    int   w0;
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b1;
    bus.q_async = 4'h0;
    clr_tally();

    // Test 1: first acquisition
    tick();
    tick();
    check_reset_vals("t1");
    acquire_check("t1");

    // Test 2: A down to 0 then wrap to F
    clr_tally();
    for (int v = 9; v >= 0; v--) hold(4'(v), 8);
    hold(4'hF, 8);
    check_val("t2_steps", 32'(n_step), 32'd11);
    check_val("t2_skips", 32'(n_skip), 32'd0);
    check_val("t2_wraps", 32'(n_wrap), 32'd1);
    check_val("t2_count", 32'(bus.count), 32'hF);
    check_val("t2_wcnt",  32'(bus.wrap_count), 32'd1);
    check_val("t2_seg",   32'(bus.seg), 32'b0001110);

    // Test 3: one-clock ripple glitch from 8 towards 7
    for (int v = 14; v >= 8; v--) hold(4'(v), 8);
    check_val("t3_start", 32'(bus.count), 32'h8);
    check_val("t3_seg8",  32'(bus.seg), 32'b0000000);
    clr_tally();
    hold(4'h0, 1);
    hold(4'h7, 8);
    check_val("t3_no_zero", 32'(zero_seen), 32'h0);
    check_val("t3_steps",   32'(n_step), 32'd1);
    check_val("t3_skips",   32'(n_skip), 32'd0);
    check_val("t3_count",   32'(bus.count), 32'h7);
    check_val("t3_seg7",    32'(bus.seg), 32'b1111000);

    // Test 4: illegal jump 5 -> 2
    hold(4'h6, 8);
    hold(4'h5, 8);
    clr_tally();
    hold(4'h2, 8);
    check_val("t4_skips", 32'(n_skip), 32'd1);
    check_val("t4_steps", 32'(n_step), 32'd0);
    check_val("t4_wraps", 32'(n_wrap), 32'd0);
    check_val("t4_count", 32'(bus.count), 32'h2);

    // Test 5: pause after 16 idle cycles, cleared by the next change
    bus.q_async = 4'h1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.count == 4'h1) found = 1'b1;
    end
    check_val("t5_acc1_seen", 32'(found), 32'h1);
    check_val("t5_paused_acc", 32'(bus.paused), 32'h0);
    repeat (15) tick();
    check_val("t5_paused_15", 32'(bus.paused), 32'h0);
    tick();
    check_val("t5_paused_16", 32'(bus.paused), 32'h1);
    repeat (4) tick();
    check_val("t5_paused_20", 32'(bus.paused), 32'h1);
    bus.q_async = 4'h0;
    found       = 1'b0;
    prev_paused = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev_paused = bus.paused;
      tick();
      if (bus.count == 4'h0) found = 1'b1;
    end
    check_val("t5_acc0_seen", 32'(found), 32'h1);
    check_val("t5_paused_before", 32'(prev_paused), 32'h1);
    check_val("t5_paused_clear",  32'(bus.paused), 32'h0);
    check_val("t5_step",          32'(bus.step), 32'h1);

    // Test 6a: five full wraps, 2-bit wrap counter saturates at 3
    clr_tally();
    for (int k = 0; k < 5; k++) begin
      w0 = n_wrap;
      hold(4'hF, 8);
      check_val("t6_wrap_pulse", 32'(n_wrap), 32'(w0 + 1));
      check_val("t6_wcnt", 32'(bus.wrap_count), (k + 2 > 3) ? 32'd3 : 32'(k + 2));
      for (int v = 14; v >= 0; v--) hold(4'(v), 8);
    end
    check_val("t6_skips", 32'(n_skip), 32'd0);
    check_val("t6_steps", 32'(n_step), 32'd80);

    // Test 6b: one-clock reset mid-TRACK, then reacquire
    reset = 1'b1;
    tick();
    check_reset_vals("t6");
    acquire_check("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
